// File: rtl/serial_neg_pkg.sv
// rtl/serial_neg_pkg.sv - shared types and limits for the serial negation controller
package serial_neg_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/serial_negate_ctrl_cell.sv
// rtl/serial_negate_ctrl_cell.sv - bit-serial two's-complement cell, LSB first
module serial_negate_ctrl_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic data_in,
  output logic data_out
);

  logic seen_q, seen_d;
  logic out_q, out_d;

  // Bits up to and including the first 1 pass through; later bits invert.
  always_comb begin
    seen_d = seen_q;
    out_d  = out_q;
    if (clr) begin
      seen_d = 1'b0;
      out_d  = 1'b0;
    end else begin
      seen_d = seen_q | data_in;
      out_d  = seen_q ^ data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      out_q  <= out_d;
    end
  end

  assign data_out = out_q;

endmodule

// File: rtl/serial_negate_ctrl.sv
// rtl/serial_negate_ctrl.sv - word-level sequencer around the bit-serial negation cell
import serial_neg_pkg::*;

module serial_negate_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             ovf_q, ovf_d;
  logic             cell_clr, cell_din, cell_dout;

  serial_negate_ctrl_cell u_cell (
    .clk      (clk),
    .rst      (rst),
    .clr      (cell_clr),
    .data_in  (cell_din),
    .data_out (cell_dout)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    cell_clr   = 1'b0;
    cell_din   = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          shreg_d = in_data;
          ovf_d   = (in_data == MOST_NEG);
          state_d = CLR;
        end
      end
      CLR: begin
        cell_clr = 1'b1;
        cnt_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        cell_din = shreg_q[0];
        shreg_d  = shreg_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Cell output lags its input by one cycle, so the first shift has nothing to capture.
        if (cnt_q != '0) begin
          res_d = {cell_dout, res_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_CNT) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        res_d      = {cell_dout, res_q[WIDTH-1:1]};
        out_data_d = res_d;
        state_d    = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      res_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_data = out_data_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// tb/tb_serial_negate_ctrl.sv - directed and swept checks of serial_negate_ctrl at WIDTH 8 and 16
module tb_serial_negate_ctrl;

  logic        clk;
  logic        rst;

  logic        in_valid8, in_ready8, out_valid8, out_ovf8, out_ready8, busy8;
  logic [7:0]  in_data8, out_data8;

  logic        in_valid16, in_ready16, out_valid16, out_ovf16, out_ready16, busy16;
  logic [15:0] in_data16, out_data16;

  int tests;
  int fails;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
    logic       exp_ovf;
    int         stall;
    bit         noise;
  } vec_t;

  vec_t vecs[10];

  serial_negate_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_data   (in_data8),
    .in_ready  (in_ready8),
    .out_valid (out_valid8),
    .out_data  (out_data8),
    .out_ovf   (out_ovf8),
    .out_ready (out_ready8),
    .busy      (busy8)
  );

  serial_negate_ctrl #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_data   (in_data16),
    .in_ready  (in_ready16),
    .out_valid (out_valid16),
    .out_data  (out_data16),
    .out_ovf   (out_ovf16),
    .out_ready (out_ready16),
    .busy      (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run8(input vec_t v);
    int lat;
    int bad;
    int stall_bad;
    in_data8   = v.din;
    in_valid8  = 1'b1;
    out_ready8 = (v.stall == 0);
    chk("in_ready_before_accept", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    in_data8  = v.noise ? 8'h33 : 8'h00;
    lat = 0;
    bad = 0;
    while (!out_valid8 && lat < 40) begin
      if (!busy8 || in_ready8) bad++;
      if (v.noise) begin
        in_valid8 = lat[0];
        in_data8  = 8'h33;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid8 = 1'b0;
    chk("latency8", lat, 10);
    chk("out_data8", out_data8, v.exp);
    chk("out_ovf8", out_ovf8, v.exp_ovf);
    chk("busy_while_working", bad, 0);
    stall_bad = 0;
    for (int i = 0; i < v.stall; i++) begin
      @(posedge clk); #1;
      if (!out_valid8 || out_data8 !== v.exp || out_ovf8 !== v.exp_ovf || in_ready8 || !busy8)
        stall_bad++;
    end
    if (v.stall > 0) chk("stall_hold", stall_bad, 0);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("single_output", out_valid8, 0);
    chk("idle_after_output", in_ready8, 1);
  endtask

  initial begin
    int lat;
    int bad;
    logic [15:0] op;
    logic [15:0] exp16;

    tests = 0;
    fails = 0;
    vecs[0] = '{8'h05, 8'hFB, 1'b0, 0,  1'b0};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 0,  1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 0,  1'b0};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 20, 1'b0};
    vecs[4] = '{8'h0C, 8'hF4, 1'b0, 0,  1'b1};
    vecs[5] = '{8'h01, 8'hFF, 1'b0, 0,  1'b0};
    vecs[6] = '{8'h7F, 8'h81, 1'b0, 2,  1'b0};
    vecs[7] = '{8'h40, 8'hC0, 1'b0, 0,  1'b0};
    vecs[8] = '{8'hFE, 8'h02, 1'b0, 1,  1'b0};
    vecs[9] = '{8'hAA, 8'h56, 1'b0, 0,  1'b0};

    rst = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_out_data", out_data8, 0);
    chk("rst_out_ovf", out_ovf8, 0);
    chk("rst_busy", busy8, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run8(vecs[i]);

    // Reset during the third SHIFT cycle discards the word.
    in_data8 = 8'h7E; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_rst", busy8, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_in_ready", in_ready8, 1);
    chk("rst_mid_busy", busy8, 0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid8) bad++;
      @(posedge clk); #1;
    end
    chk("no_output_after_rst", bad, 0);
    run8('{8'h01, 8'hFF, 1'b0, 0, 1'b0});

    for (int n = 0; n < 1000; n++) begin
      case (n)
        0: op = 16'h0000;
        1: op = 16'h8000;
        2: op = 16'hFFFF;
        3: op = 16'h0001;
        default: op = 16'($urandom);
      endcase
      exp16 = 16'(17'h10000 - {1'b0, op});
      in_data16 = op; in_valid16 = 1'b1; out_ready16 = 1'b0;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      in_data16 = 16'($urandom);
      lat = 0;
      while (!out_valid16 && lat < 60) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("latency16", lat, 18);
      chk("out_data16", out_data16, exp16);
      chk("out_ovf16", out_ovf16, (op == 16'h8000));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      chk("stall16_hold", out_data16, exp16);
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
      chk("single_output16", out_valid16, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
